// File: rtl/dmem_mmio_if.sv
// Core-side data memory bus: store strobe, byte address, store data and combinational load data.
interface dmem_mmio_if;
    logic        memwrite;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output memwrite, output a, output wd, input rd);
    modport slave  (input memwrite, input a, input wd, output rd);
endinterface

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO window (LED, cycle counter, compare timer) behind the single-cycle MIPS core.
// Define DMEM_MMIO_TIMER_EN to build the compare timer; otherwise its offsets read 0 and irq is 0.
module dmem_mmio #(
    parameter int          RAM_AW      = 6,
    parameter int          LED_W       = 8,
    parameter logic [31:0] CYC_RST_VAL = 32'h0  // test hook: cycle counter value loaded by reset
) (
    input  logic             clk,
    input  logic             reset,
    dmem_mmio_if.slave       bus,
    output logic [LED_W-1:0] leds,
    output logic             irq
);
    localparam logic [2:0] OFF_LED   = 3'd0;
    localparam logic [2:0] OFF_CYCLE = 3'd1;

    logic              is_mmio;
    logic [2:0]        sel;
    logic [RAM_AW-1:0] idx;
    logic              wr_ram;
    logic              wr_led;
    logic [31:0]       mem_q [2**RAM_AW];
    logic [LED_W-1:0]  led_q, led_d;
    logic [31:0]       cycle_q, cycle_d;
    logic [31:0]       tmr_rd;
    logic              unused_a;

    assign is_mmio  = (bus.a[31:16] == 16'hFFFF);
    assign sel      = bus.a[4:2];
    assign idx      = bus.a[RAM_AW+1:2];
    assign wr_ram   = bus.memwrite && !is_mmio;
    assign wr_led   = bus.memwrite && is_mmio && (sel == OFF_LED);
    assign unused_a = ^{bus.a[1:0], bus.a[15:5]};

    // RAM is never reset; loads see the pre-edge contents during a store to the same word
    always_ff @(posedge clk) begin
        if (wr_ram) mem_q[idx] <= bus.wd;
    end

    always_comb begin
        led_d   = led_q;
        cycle_d = cycle_q + 32'd1;
        if (wr_led) led_d = bus.wd[LED_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q   <= '0;
            cycle_q <= CYC_RST_VAL;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
        end
    end

    assign leds = led_q;

`ifdef DMEM_MMIO_TIMER_EN
    localparam logic [2:0] OFF_TCMP  = 3'd2;
    localparam logic [2:0] OFF_TCNT  = 3'd3;
    localparam logic [2:0] OFF_TCTRL = 3'd4;
    localparam logic [2:0] OFF_TSTAT = 3'd5;

    logic [31:0] tcmp_q, tcmp_d, tcnt_q, tcnt_d;
    logic        en_q, en_d, ar_q, ar_d, ie_q, ie_d, flag_q, flag_d;
    logic        match;
    logic        wr_tcmp, wr_tcnt, wr_tctrl, wr_tstat;

    assign wr_tcmp  = bus.memwrite && is_mmio && (sel == OFF_TCMP);
    assign wr_tcnt  = bus.memwrite && is_mmio && (sel == OFF_TCNT);
    assign wr_tctrl = bus.memwrite && is_mmio && (sel == OFF_TCTRL);
    assign wr_tstat = bus.memwrite && is_mmio && (sel == OFF_TSTAT);
    assign match    = en_q && (tcnt_q == tcmp_q);

    // Hardware update first, then software writes override; flag set wins over W1C last
    always_comb begin
        tcmp_d = tcmp_q;
        tcnt_d = tcnt_q;
        en_d   = en_q;
        ar_d   = ar_q;
        ie_d   = ie_q;
        flag_d = flag_q;
        if (en_q) begin
            if (match) begin
                if (ar_q) tcnt_d = '0;
                else      en_d   = 1'b0;
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end
        if (wr_tcmp)  tcmp_d = bus.wd;
        if (wr_tcnt)  tcnt_d = bus.wd;
        if (wr_tctrl) {ie_d, ar_d, en_d} = bus.wd[2:0];
        if (wr_tstat && bus.wd[0]) flag_d = 1'b0;
        if (match) flag_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcmp_q <= '0;
            tcnt_q <= '0;
            en_q   <= 1'b0;
            ar_q   <= 1'b0;
            ie_q   <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            tcmp_q <= tcmp_d;
            tcnt_q <= tcnt_d;
            en_q   <= en_d;
            ar_q   <= ar_d;
            ie_q   <= ie_d;
            flag_q <= flag_d;
        end
    end

    assign irq = flag_q && ie_q;

    always_comb begin
        tmr_rd = '0;
        case (sel)
            OFF_TCMP:  tmr_rd = tcmp_q;
            OFF_TCNT:  tmr_rd = tcnt_q;
            OFF_TCTRL: tmr_rd[2:0] = {ie_q, ar_q, en_q};
            OFF_TSTAT: tmr_rd[0] = flag_q;
            default:   tmr_rd = '0;
        endcase
    end
`else
    assign irq    = 1'b0;
    assign tmr_rd = '0;
`endif

    always_comb begin
        bus.rd = mem_q[idx];
        if (is_mmio) begin
            bus.rd = tmr_rd;
            if (sel == OFF_LED) begin
                bus.rd = '0;
                bus.rd[LED_W-1:0] = led_q;
            end else if (sel == OFF_CYCLE) begin
                bus.rd = cycle_q;
            end
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: spec-level model checked every cycle plus directed literal expectations.
module tb_dmem_mmio;
`ifdef DMEM_MMIO_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif
    localparam logic [31:0] LED   = 32'hFFFF0000;
    localparam logic [31:0] CYC   = 32'hFFFF0004;
    localparam logic [31:0] TCMP  = 32'hFFFF0008;
    localparam logic [31:0] TCNT  = 32'hFFFF000C;
    localparam logic [31:0] TCTRL = 32'hFFFF0010;
    localparam logic [31:0] TSTAT = 32'hFFFF0014;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] leds, leds2;
    logic       irq, irq2;
    int         chk_cnt = 0;
    int         pass_cnt = 0;

    dmem_mmio_if bus();
    dmem_mmio_if bus2();

    dmem_mmio #(.RAM_AW(6), .LED_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus), .leds(leds), .irq(irq));
    dmem_mmio #(.RAM_AW(6), .LED_W(8), .CYC_RST_VAL(32'hFFFFFFFE)) dut_wrap (
        .clk(clk), .reset(reset), .bus(bus2), .leds(leds2), .irq(irq2));

    always #5 clk = ~clk;

    // Model state, following the register map directly
    logic [31:0] m_mem [64];
    bit          m_ok  [64];
    logic [7:0]  m_led;
    logic [31:0] m_cyc, m_tcmp, m_tcnt;
    logic        m_en, m_ar, m_ie, m_flag;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    task automatic model_step();
        logic [31:0] a, wd;
        logic        we, mm, hit;
        int          off, idx;
        a = bus.a; wd = bus.wd; we = bus.memwrite;
        mm = (a[31:16] == 16'hFFFF);
        off = int'(a[4:2]);
        idx = int'(a[7:2]);
        if (we && !mm) begin
            m_mem[idx] = wd;
            m_ok[idx] = 1'b1;
        end
        if (reset) begin
            m_led = '0; m_cyc = '0; m_tcmp = '0; m_tcnt = '0;
            m_en = 1'b0; m_ar = 1'b0; m_ie = 1'b0; m_flag = 1'b0;
        end else begin
            m_cyc = m_cyc + 32'd1;
            hit = m_en && (m_tcnt == m_tcmp);
            if (m_en) begin
                if (!hit)     m_tcnt = m_tcnt + 32'd1;
                else if (m_ar) m_tcnt = '0;
                else          m_en = 1'b0;
            end
            if (we && mm && off == 0) m_led = wd[7:0];
            if (we && mm && TIMER) begin
                if (off == 2) m_tcmp = wd;
                if (off == 3) m_tcnt = wd;
                if (off == 4) begin m_en = wd[0]; m_ar = wd[1]; m_ie = wd[2]; end
                if (off == 5 && wd[0]) m_flag = 1'b0;
            end
            if (hit) m_flag = 1'b1;
        end
    endtask

    // Bit 32 flags whether the expected value is known (unwritten RAM is not)
    function automatic logic [32:0] exp_rd(input logic [31:0] a);
        if (a[31:16] != 16'hFFFF) return {m_ok[a[7:2]], m_mem[a[7:2]]};
        case (a[4:2])
            3'd0: return {1'b1, 24'h0, m_led};
            3'd1: return {1'b1, m_cyc};
            3'd2: return {1'b1, TIMER ? m_tcmp : 32'h0};
            3'd3: return {1'b1, TIMER ? m_tcnt : 32'h0};
            3'd4: return {1'b1, TIMER ? {29'h0, m_ie, m_ar, m_en} : 32'h0};
            3'd5: return {1'b1, TIMER ? {31'h0, m_flag} : 32'h0};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    initial begin : compare
        logic [32:0] e;
        for (int i = 0; i < 64; i++) m_ok[i] = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            #3;
            e = exp_rd(bus.a);
            if (e[32]) chk("model_rd", bus.rd, e[31:0]);
            chk("model_leds", {24'h0, leds}, {24'h0, m_led});
            chk("model_irq", {31'h0, irq}, {31'h0, m_flag & m_ie});
        end
    end

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.memwrite = we; bus.a = addr; bus.wd = data;
        #2;
    endtask

    initial begin : stim
        reset = 1'b1;
        bus.memwrite = 1'b0; bus.a = LED; bus.wd = '0;
        bus2.memwrite = 1'b0; bus2.a = CYC; bus2.wd = '0;
        drive(0, LED, 0);
        drive(0, LED, 0);
        chk("reset_leds", {24'h0, leds}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);

        // Cycle counter and its wrap (second instance resets to 0xFFFFFFFE)
        @(negedge clk);
        reset = 1'b0; bus.a = CYC;
        #2;
        chk("cycle_0", bus.rd, 32'd0);
        chk("wrap_0", bus2.rd, 32'hFFFFFFFE);
        drive(0, CYC, 0);
        chk("wrap_1", bus2.rd, 32'hFFFFFFFF);
        drive(0, CYC, 0);
        chk("wrap_2", bus2.rd, 32'h0);
        repeat (8) drive(0, CYC, 0);
        chk("cycle_10", bus.rd, 32'd10);

        // RAM store/load with aliasing
        drive(1, 32'h10, 32'hDEADBEEF);
        drive(0, 32'h10, 0);
        chk("ram_load", bus.rd, 32'hDEADBEEF);
        drive(0, 32'h110, 0);
        chk("ram_alias", bus.rd, 32'hDEADBEEF);
        drive(0, 32'h13, 0);
        chk("ram_bytebits", bus.rd, 32'hDEADBEEF);

        // Read during write
        drive(1, 32'h20, 32'h5);
        drive(1, 32'h20, 32'h1);
        chk("rdw_old", bus.rd, 32'h5);
        drive(0, 32'h20, 0);
        chk("rdw_new", bus.rd, 32'h1);

        // LED and MMIO isolation from RAM
        drive(1, 32'h0, 32'h12345678);
        drive(1, LED, 32'h1A5);
        drive(0, LED, 0);
        chk("led_out", {24'h0, leds}, 32'hA5);
        chk("led_read", bus.rd, 32'hA5);
        drive(0, 32'h0, 0);
        chk("ram0_kept", bus.rd, 32'h12345678);
        drive(1, 32'hFFFF0018, 32'hFFFFFFFF);
        drive(0, 32'hFFFF0018, 0);
        chk("reserved_0", bus.rd, 32'h0);

`ifdef DMEM_MMIO_TIMER_EN
        // One-shot: TCMP=3
        drive(1, TCMP, 3);
        drive(1, TCNT, 0);
        drive(1, TCTRL, 5);
        for (int i = 0; i < 4; i++) begin
            drive(0, TCNT, 0);
            chk("oneshot_tcnt", bus.rd, i);
            chk("oneshot_irq_low", {31'h0, irq}, 32'h0);
        end
        drive(0, TCNT, 0);
        chk("oneshot_hold", bus.rd, 32'd3);
        chk("oneshot_irq", {31'h0, irq}, 32'h1);
        drive(0, TCTRL, 0);
        chk("oneshot_en_clr", bus.rd, 32'h4);
        drive(1, TSTAT, 0);
        drive(0, TSTAT, 0);
        chk("w0_no_effect", bus.rd, 32'h1);
        drive(1, TSTAT, 1);
        drive(0, TSTAT, 0);
        chk("w1c_flag", bus.rd, 32'h0);
        chk("w1c_irq", {31'h0, irq}, 32'h0);

        // Autoreload, TCMP=2
        drive(1, TCMP, 2);
        drive(1, TCNT, 0);
        drive(1, TCTRL, 7);
        for (int i = 0; i < 6; i++) begin
            drive(0, TCNT, 0);
            chk("auto_tcnt", bus.rd, i % 3);
            if (i == 3) chk("auto_irq", {31'h0, irq}, 32'h1);
        end
        drive(0, TCNT, 0);
        drive(0, TCNT, 0);
        drive(1, TSTAT, 1);
        drive(0, TSTAT, 0);
        chk("set_beats_w1c", bus.rd, 32'h1);
        drive(0, TCNT, 0);
        drive(1, TCNT, 32'h100);
        chk("match_cycle_tcnt", bus.rd, 32'h2);
        drive(0, TCNT, 0);
        chk("sw_tcnt_wins", bus.rd, 32'h100);

        // TCTRL write on a one-shot match keeps en
        drive(1, TCTRL, 0);
        drive(1, TCMP, 5);
        drive(1, TCNT, 5);
        drive(1, TCTRL, 1);
        drive(1, TCTRL, 1);
        drive(0, TCTRL, 0);
        chk("tctrl_beats_clr", bus.rd, 32'h1);

        // Reset mid-count
        drive(1, TCTRL, 7);
        drive(0, TCNT, 0);
        @(negedge clk);
        reset = 1'b1; bus.memwrite = 1'b0;
        @(negedge clk);
        reset = 1'b0; bus.a = TCNT;
        #2;
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_tcnt", bus.rd, 32'h0);
`else
        drive(1, TCMP, 3);
        drive(1, TCTRL, 5);
        drive(0, TCMP, 0);
        chk("notimer_tcmp", bus.rd, 32'h0);
        drive(0, TCTRL, 0);
        chk("notimer_tctrl", bus.rd, 32'h0);
        repeat (6) drive(0, TSTAT, 0);
        chk("notimer_tstat", bus.rd, 32'h0);
        chk("notimer_irq", {31'h0, irq}, 32'h0);
`endif
        repeat (3) drive(0, LED, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory stage that sits directly downstream of the single-cycle MIPS core.
- Consumes the core's memwrite, aluout (address) and writedata, and returns readdata in the same cycle.
- Combines a word-addressed data RAM with a small memory-mapped I/O window: LED output register, free-running cycle counter, and a compare timer with interrupt flag.

Parameters:
- RAM_AW, 6, log2 of RAM depth in 32-bit words (default 64 words)
- LED_W, 8, width of LED output register

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- memwrite  input  1  store strobe from core, sampled at rising edge
- a  input  32  byte address (core aluout)
- wd  input  32  store data (core writedata)
- rd  output  32  load data to core (readdata), combinational from a
- leds  output  LED_W  LED register contents
- irq  output  1  timer interrupt, TSTAT.flag AND TCTRL.ie

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. It clears all MMIO registers and the cycle counter to 0, so leds=0 and irq=0 after the reset edge. RAM contents are not reset.
- Decode: a[31:16]==16'hFFFF selects MMIO, register selected by a[4:2]. Otherwise RAM at word index a[RAM_AW+1:2]; upper address bits are aliased and a[1:0] is ignored.
- RAM read: combinational, rd = mem[index] in the same cycle.
- RAM write: at the rising edge when memwrite=1.
- Read-during-write to the same word: rd shows the old value until the edge.
- MMIO map (offset from 0xFFFF0000):
  - 0x00 LED: R/W, low LED_W bits used, upper bits read 0.
  - 0x04 CYCLE: RO; increments by 1 every cycle out of reset, wraps 0xFFFFFFFF->0; reads 0 in the first cycle after reset.
  - 0x08 TCMP: R/W, 32-bit compare value.
  - 0x0C TCNT: R/W; a write loads the count.
  - 0x10 TCTRL: bit0 en, bit1 autoreload, bit2 ie; other bits read 0.
  - 0x14 TSTAT: bit0 flag; write 1 to clear, write 0 has no effect.
  - 0x18, 0x1C: read 0, writes ignored. MMIO accesses never touch RAM.
- Timer, evaluated each cycle while en=1:
  - If TCNT==TCMP: set flag. If autoreload=1, TCNT<=0 next cycle; else en<=0 (one-shot) and TCNT holds.
  - Otherwise TCNT<=TCNT+1, wrapping at 2^32.
  - While en=0, TCNT holds.
- Priority rules:
  - Software write to TCNT beats increment or reload that cycle.
  - Software write to TCTRL beats the one-shot en clear.
  - Hardware flag set beats a simultaneous W1C.
- Timing: irq is a registered-state function with no added latency beyond the flag register, asserted the cycle after the match edge. Reset asserted mid-count abandons the timer and clears flag and irq at that edge.

Optional Feature:
- Macro: DMEM_MMIO_TIMER_EN.
- Defined: TCMP, TCNT, TCTRL and TSTAT implemented as above.
- Undefined: offsets 0x08-0x14 read 0 and ignore writes, irq tied to 0, no timer flops synthesized. LED and CYCLE are unaffected.

Test Plan:
- RAM store/load: store 0xDEADBEEF to a=0x00000010, then load a=0x00000010 -> rd=0xDEADBEEF. Load a=0x00000110 (alias, RAM_AW=6) -> same value. Load a=0x00000013 -> same value.
- Read-during-write: memwrite=1, a=0x20, wd=0x1 with old mem=0x5 -> rd=0x5 during that cycle, 0x1 the next cycle.
- LED/MMIO isolation: store 0x1A5 to 0xFFFF0000 -> leds=0xA5, read returns 0x000000A5. RAM word 0 unchanged. Read 0xFFFF0018 -> 0.
- Cycle counter: release reset, read 0xFFFF0004 at cycle 0 -> 0, at cycle 10 -> 10. Force CYCLE to 0xFFFFFFFE via a test hook -> wraps to 0 after two cycles.
- One-shot timer: TCMP=3, TCNT=0, TCTRL=0x5 -> flag and irq rise the cycle after TCNT reaches 3. en reads 0, TCNT holds 3. Write TSTAT=1 -> irq=0.
- Autoreload plus simultaneous events: TCMP=2, TCTRL=0x7 -> irq periodic with TCNT sequence 0,1,2,0,1,2. W1C issued on a match cycle leaves flag=1. A TCNT write of 0x100 on a match cycle -> TCNT=0x100.
